// File: rtl/mux2_rr_arbiter_if.sv
// Request, data and grant bundle between two requesters and the shared 2:1 mux arbiter.
// Latency: none. This is wiring only.
// Backpressure: none. The grants are the only flow control seen by the requesters.
interface mux2_rr_arbiter_if #(
  parameter int WIDTH = 1
);
  logic             req0;
  logic             req1;
  logic [WIDTH-1:0] i0;
  logic [WIDTH-1:0] i1;
  logic             gnt0;
  logic             gnt1;
  logic             sel;
  logic [WIDTH-1:0] y;
  logic             y_valid;

  // Requester side: drives requests and data, observes grants and mux output.
  modport master (
    output req0, req1, i0, i1,
    input  gnt0, gnt1, sel, y, y_valid
  );

  // Arbiter side.
  modport slave (
    input  req0, req1, i0, i1,
    output gnt0, gnt1, sel, y, y_valid
  );
endinterface

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter owning a 2:1 mux select; it registers the selected data with a valid flag.
// Latency: req to gnt/sel takes 1 edge; req to y/y_valid takes 2 edges.
// Backpressure: none. Requesters hold req high while they want the mux, and hold time is capped at MAX_HOLD when contended.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mux2_rr_arbiter_if.slave    bus
);

  // The hold counter only needs to reach MAX_HOLD-1. MAX_HOLD==1 still gets a 1-bit counter.
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             sel_q, sel_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic             cap;

  // Next-state arbitration, hold counter and last-grant bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 && bus.req1) state_d = last_q ? G0 : G1;
        else if (bus.req0)        state_d = G0;
        else if (bus.req1)        state_d = G1;
        else                      state_d = IDLE;
      end
      G0: begin
        if (!bus.req0)                   state_d = bus.req1 ? G1 : IDLE;
        else if (bus.req1 && cnt_q == CNT_MAX) state_d = G1;
        else                             state_d = G0;
      end
      G1: begin
        if (!bus.req1)                   state_d = bus.req0 ? G0 : IDLE;
        else if (bus.req0 && cnt_q == CNT_MAX) state_d = G0;
        else                             state_d = G1;
      end
      default: state_d = IDLE;
    endcase

    // A fresh grant, including a direct G0<->G1 handover, restarts the hold count.
    // Holding a grant counts up and saturates so a lone requester can keep it indefinitely.
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end

    if (state_d == G0) last_d = 1'b0;
    if (state_d == G1) last_d = 1'b1;
  end

  // Moore decode of the next state, so grant and select come straight from flops.
  always_comb begin
    gnt0_d = (state_d == G0);
    gnt1_d = (state_d == G1);
    sel_d  = (state_d == G1);
  end

  // Capture mux data only while the current owner still requests. Otherwise y keeps its value.
  always_comb begin
    cap       = ((state_q == G0) && bus.req0) || ((state_q == G1) && bus.req1);
    y_valid_d = cap;
    y_d       = y_q;
    if (cap) y_d = sel_q ? bus.i1 : bus.i0;
  end

  // FSM state, counters and registered outputs. Reset clears everything at once, and last=1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      sel_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      sel_q     <= sel_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

  assign bus.gnt0    = gnt0_q;
  assign bus.gnt1    = gnt1_q;
  assign bus.sel     = sel_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;

endmodule
